// File: rtl/ahb_manager_pack.sv
// rtl/ahb_manager_pack.sv - shared AHB transfer types and helpers for manager/arbiter
package ahb_manager_pack;

  localparam int AHB_MAX_MGR = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } t_hburst;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } t_hresp;

  // Beats in a fixed-length burst; SINGLE and undefined-length INCR count as 1.
  function automatic logic [4:0] burst_beats(input t_hburst b);
    case (b)
      INCR4, WRAP4:   burst_beats = 5'd4;
      INCR8, WRAP8:   burst_beats = 5'd8;
      INCR16, WRAP16: burst_beats = 5'd16;
      default:        burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - arbiter bus-side signal bundle
// master modport: the arbiter (samples requests/bus status, drives grant/owner/mask)
// slave modport:  the fabric side (drives requests/bus status, observes grant/owner/mask)
interface ahb_arbiter_if #(
  parameter int N_MGR = 4
) ();
  import ahb_manager_pack::*;

  localparam int IW = $clog2(N_MGR);

  logic [N_MGR-1:0] i_hbusreq;
  t_htrans          i_htrans;
  t_hburst          i_hburst;
  logic             i_hready;
  t_hresp           i_hresp;
  logic [N_MGR-1:0] i_hsplit;
  logic [N_MGR-1:0] o_hgrant;
  logic [IW-1:0]    o_hmaster;
  logic [IW-1:0]    o_hmaster_d;
  logic [N_MGR-1:0] o_split_mask;

  modport master (
    input  i_hbusreq, i_htrans, i_hburst, i_hready, i_hresp, i_hsplit,
    output o_hgrant, o_hmaster, o_hmaster_d, o_split_mask
  );

  modport slave (
    output i_hbusreq, i_htrans, i_hburst, i_hready, i_hresp, i_hsplit,
    input  o_hgrant, o_hmaster, o_hmaster_d, o_split_mask
  );
endinterface

// File: rtl/ahb_arbiter_rr_pick.sv
// rtl/ahb_arbiter_rr_pick.sv - combinational round-robin picker
// i_elig: eligible vector; i_start: first index searched
// o_found: any eligible bit set; o_idx: first eligible index at/after i_start (wrapping)
module ahb_arbiter_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW:0] pos;

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    pos     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, i_start} + (IW + 1)'(i);
      if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
      if (i_elig[pos[IW-1:0]]) begin
        o_found = 1'b1;
        o_idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB arbiter with burst lock and SPLIT masking
// i_hclk: bus clock; i_hreset_n: async active-low reset
// bus: requests, muxed HTRANS/HBURST, HREADY, HRESP, split releases in;
//      grant vector, address/data-phase owner, split mask out (all registered)
module ahb_arbiter
  import ahb_manager_pack::*;
#(
  parameter int N_MGR   = 4,
  parameter int DEF_MGR = 0
) (
  input logic            i_hclk,
  input logic            i_hreset_n,
  ahb_arbiter_if.master  bus
);

  localparam int IW = $clog2(N_MGR);
  localparam logic [N_MGR-1:0] GRANT_RST = N_MGR'(1) << DEF_MGR;
  localparam logic [IW-1:0]    DEF_IDX   = IW'(DEF_MGR);

  logic [N_MGR-1:0] hgrant_q, hgrant_d;
  logic [N_MGR-1:0] split_mask_q, split_mask_d;
  logic [IW-1:0]    hmaster_q, hmaster_d;
  logic [IW-1:0]    hmaster_dph_q, hmaster_dph_d;
  logic [IW-1:0]    last_gnt_q, last_gnt_d;
  logic [4:0]       beat_left_q, beat_left_d;

  logic             first_sr;
  logic             arb_ok;
  logic [N_MGR-1:0] split_set;
  logic [N_MGR-1:0] mask_now;
  logic [N_MGR-1:0] elig;
  logic [IW-1:0]    start_idx;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    grant_idx;

  ahb_arbiter_rr_pick #(.N(N_MGR)) u_pick (
    .i_elig  (elig),
    .i_start (start_idx),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  always_comb begin
    // First cycle of the two-cycle SPLIT/RETRY response.
    first_sr  = ~bus.i_hready & ((bus.i_hresp == SPLIT) | (bus.i_hresp == RETRY));
    split_set = '0;
    if (first_sr && (bus.i_hresp == SPLIT)) split_set[hmaster_dph_q] = 1'b1;
    // Set wins over a same-cycle release of the same bit.
    split_mask_d = (split_mask_q & ~bus.i_hsplit) | split_set;
    // The manager being split is already excluded from this edge's decision.
    mask_now  = split_mask_q | split_set;
    elig      = bus.i_hbusreq & ~mask_now;
    start_idx = (last_gnt_q == IW'(N_MGR - 1)) ? '0 : last_gnt_q + IW'(1);

    beat_left_d = beat_left_q;
    if (bus.i_hresp != OKAY) begin
      beat_left_d = '0;
    end else if (bus.i_hready) begin
      if (bus.i_htrans == NONSEQ)
        beat_left_d = burst_beats(bus.i_hburst) - 5'd1;
      else if (bus.i_htrans == SEQ && beat_left_q != '0)
        beat_left_d = beat_left_q - 5'd1;
    end

    // Judged on the count after this beat, so the grant hands over while the
    // final beat is accepted and the NONSEQ of a fixed burst already locks.
    arb_ok = (beat_left_d == '0) | (bus.i_htrans == IDLE) |
             (bus.i_hburst == INCR) | (bus.i_hburst == SINGLE);

    hgrant_d   = hgrant_q;
    last_gnt_d = last_gnt_q;
    if ((bus.i_hready & arb_ok) | first_sr) begin
      if (pick_found) begin
        hgrant_d           = '0;
        hgrant_d[pick_idx] = 1'b1;
        last_gnt_d         = pick_idx;
      end else if (!mask_now[DEF_MGR]) begin
        hgrant_d   = GRANT_RST;
        last_gnt_d = DEF_IDX;
      end else begin
        hgrant_d = '0;
      end
    end

    grant_idx = DEF_IDX;
    for (int i = 0; i < N_MGR; i++) begin
      if (hgrant_q[i]) grant_idx = IW'(i);
    end
    hmaster_d     = bus.i_hready ? grant_idx : hmaster_q;
    hmaster_dph_d = bus.i_hready ? hmaster_q : hmaster_dph_q;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      hgrant_q      <= GRANT_RST;
      split_mask_q  <= '0;
      hmaster_q     <= DEF_IDX;
      hmaster_dph_q <= DEF_IDX;
      last_gnt_q    <= DEF_IDX;
      beat_left_q   <= '0;
    end else begin
      hgrant_q      <= hgrant_d;
      split_mask_q  <= split_mask_d;
      hmaster_q     <= hmaster_d;
      hmaster_dph_q <= hmaster_dph_d;
      last_gnt_q    <= last_gnt_d;
      beat_left_q   <= beat_left_d;
    end
  end

  assign bus.o_hgrant     = hgrant_q;
  assign bus.o_hmaster    = hmaster_q;
  assign bus.o_hmaster_d  = hmaster_dph_q;
  assign bus.o_split_mask = split_mask_q;

endmodule
